fifo_uniq_push_arb: RTL and testbench

- Round-robin arbiter and sequencer that shares one content-checked FIFO among NUM_REQ requesters.
- For each granted request it first asks the FIFO's check port whether the word is already queued, then writes it only if it is absent, and returns a per-request status.
- Sits between the pixel/command producers and the checked FIFO in the VGA datapath, so the FIFO never holds duplicate pending entries.

---
 rtl/fifo_ctrl_pkg.sv | 22 ++
 rtl/fifo_uniq_push_arb_if.sv | 40 ++++
 rtl/rr_arbiter.sv | 31 +++
 rtl/fifo_uniq_push_arb.sv | 202 ++++++++++++++++++++
 tb/tb_fifo_uniq_push_arb.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_ctrl_pkg.sv
// Shared constants for the unique-push FIFO controller: response codes, FSM encoding and
// the duplicate-counter width.
package fifo_ctrl_pkg;

    localparam int unsigned DUP_CNT_WIDTH = 16;

    typedef logic [1:0] resp_code_t;
    typedef logic [2:0] state_t;

    localparam resp_code_t RESP_PUSHED  = 2'd0;
    localparam resp_code_t RESP_DUP     = 2'd1;
    localparam resp_code_t RESP_FULL    = 2'd2;
    localparam resp_code_t RESP_TIMEOUT = 2'd3;

    localparam state_t S_IDLE     = 3'd0;
    localparam state_t S_EVAL     = 3'd1;
    localparam state_t S_CHK_REQ  = 3'd2;
    localparam state_t S_CHK_WAIT = 3'd3;
    localparam state_t S_WRITE    = 3'd4;
    localparam state_t S_RESP     = 3'd5;

endpackage

// File: rtl/fifo_uniq_push_arb_if.sv
// Bundle of requester handshake, status and checked-FIFO signals around the arbiter.
// slave is the arbiter's view; master is the requester/FIFO side.
interface fifo_uniq_push_arb_if
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ID_WIDTH   = 2,
    parameter int unsigned DATA_WIDTH = 32
) ();

    logic [NUM_REQ-1:0]            req_vld;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_dat;
    logic [NUM_REQ-1:0]            req_ack;
    logic                          resp_vld;
    logic [1:0]                    resp_code;
    logic [ID_WIDTH-1:0]           resp_id;
    logic                          busy;
    logic [DUP_CNT_WIDTH-1:0]      dup_cnt;
    logic                          ff_wren;
    logic [DATA_WIDTH-1:0]         ff_wdat;
    logic                          ff_full;
    logic                          ff_empty;
    logic                          ff_check_req;
    logic [DATA_WIDTH-1:0]         ff_check_dat;
    logic                          ff_check_res;
    logic                          ff_check_vld;

    modport slave (
        input  req_vld, req_dat, ff_full, ff_empty, ff_check_res, ff_check_vld,
        output req_ack, resp_vld, resp_code, resp_id, busy, dup_cnt,
        output ff_wren, ff_wdat, ff_check_req, ff_check_dat
    );

    modport master (
        output req_vld, req_dat, ff_full, ff_empty, ff_check_res, ff_check_vld,
        input  req_ack, resp_vld, resp_code, resp_id, busy, dup_cnt,
        input  ff_wren, ff_wdat, ff_check_req, ff_check_dat
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first unmasked request at or above ptr_i, wrapping.
module rr_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned ID_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]  req_i,
    input  logic [NUM_REQ-1:0]  mask_i,
    input  logic [ID_WIDTH-1:0] ptr_i,
    output logic [ID_WIDTH-1:0] gnt_id_o,
    output logic                gnt_vld_o
);

    logic [NUM_REQ-1:0] eff;
    logic [NUM_REQ-1:0] rot;

    assign eff = req_i & ~mask_i;
    // Rotating the doubled vector puts the pointer's requester at bit 0.
    assign rot = NUM_REQ'({eff, eff} >> ptr_i);

    always_comb begin
        gnt_vld_o = 1'b0;
        gnt_id_o  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!gnt_vld_o && rot[k]) begin
                gnt_vld_o = 1'b1;
                gnt_id_o  = ID_WIDTH'((32'(ptr_i) + k) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/fifo_uniq_push_arb.sv
// Round-robin sequencer that pushes a requester's word into the shared FIFO only when the
// FIFO's content check reports it absent, returning PUSHED/DUP/FULL/TIMEOUT per request.
module fifo_uniq_push_arb
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned ID_WIDTH    = 2,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned CHK_TIMEOUT = 40
) (
    input logic                 clk,
    input logic                 rst,
    fifo_uniq_push_arb_if.slave bus
);

    localparam int unsigned TW = $clog2(CHK_TIMEOUT) + 1;

    state_t                   state_q, state_d;
    logic [ID_WIDTH-1:0]      rr_ptr_q, rr_ptr_d;
    logic [ID_WIDTH-1:0]      cur_id_q, cur_id_d;
    logic [DATA_WIDTH-1:0]    cur_dat_q, cur_dat_d;
    logic [TW-1:0]            tmo_q, tmo_d;
    logic [DUP_CNT_WIDTH-1:0] dup_cnt_q, dup_cnt_d;
    logic                     served_q;

    logic [NUM_REQ-1:0]       req_ack_q, req_ack_d;
    logic                     resp_vld_q, resp_vld_d;
    resp_code_t               resp_code_q, resp_code_d;
    logic [ID_WIDTH-1:0]      resp_id_q, resp_id_d;
    logic                     busy_q, busy_d;
    logic                     ff_wren_q, ff_wren_d;
    logic [DATA_WIDTH-1:0]    ff_wdat_q, ff_wdat_d;
    logic                     ff_check_req_q, ff_check_req_d;
    logic [DATA_WIDTH-1:0]    ff_check_dat_q, ff_check_dat_d;

    logic [NUM_REQ-1:0]       mask;
    logic [ID_WIDTH-1:0]      gnt_id;
    logic                     gnt_vld;
    logic [DATA_WIDTH-1:0]    gnt_dat;

    // The requester served last cycle sits out one arbitration round.
    assign mask = served_q ? (NUM_REQ'(1) << cur_id_q) : '0;

    rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr_arbiter (
        .req_i     (bus.req_vld),
        .mask_i    (mask),
        .ptr_i     (rr_ptr_q),
        .gnt_id_o  (gnt_id),
        .gnt_vld_o (gnt_vld)
    );

    always_comb begin
        gnt_dat = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (gnt_id == ID_WIDTH'(k)) begin
                gnt_dat = bus.req_dat[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        cur_id_d       = cur_id_q;
        cur_dat_d      = cur_dat_q;
        tmo_d          = tmo_q;
        dup_cnt_d      = dup_cnt_q;
        req_ack_d      = '0;
        resp_vld_d     = 1'b0;
        resp_code_d    = RESP_PUSHED;
        resp_id_d      = '0;
        ff_wren_d      = 1'b0;
        ff_wdat_d      = '0;
        ff_check_req_d = 1'b0;
        ff_check_dat_d = ff_check_dat_q;

        unique case (state_q)
            S_IDLE: begin
                if (gnt_vld) begin
                    cur_id_d  = gnt_id;
                    cur_dat_d = gnt_dat;
                    state_d   = S_EVAL;
                end
            end
            S_EVAL: begin
                if (bus.ff_full) begin
                    resp_code_d = RESP_FULL;
                    state_d     = S_RESP;
                end else if (bus.ff_empty) begin
                    // A search of an empty FIFO never terminates; nothing to collide with.
                    state_d = S_WRITE;
                end else begin
                    ff_check_req_d = 1'b1;
                    ff_check_dat_d = cur_dat_q;
                    state_d        = S_CHK_REQ;
                end
            end
            S_CHK_REQ: begin
                tmo_d   = '0;
                state_d = S_CHK_WAIT;
            end
            S_CHK_WAIT: begin
                tmo_d = tmo_q + TW'(1);
                if (bus.ff_check_vld) begin
                    ff_check_dat_d = '0;
                    if (bus.ff_check_res) begin
                        resp_code_d = RESP_DUP;
                        state_d     = S_RESP;
                    end else begin
                        state_d = S_WRITE;
                    end
                end else if (tmo_q == TW'(CHK_TIMEOUT - 1)) begin
                    ff_check_dat_d = '0;
                    resp_code_d    = RESP_TIMEOUT;
                    state_d        = S_RESP;
                end
            end
            S_WRITE: begin
                state_d = S_RESP;
                if (bus.ff_full) begin
                    resp_code_d = RESP_FULL;
                end else begin
                    resp_code_d = RESP_PUSHED;
                    ff_wren_d   = 1'b1;
                    ff_wdat_d   = cur_dat_q;
                end
            end
            S_RESP: begin
                rr_ptr_d = (cur_id_q == ID_WIDTH'(NUM_REQ - 1)) ? '0 : cur_id_q + ID_WIDTH'(1);
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Response outputs are registered, so they are loaded on the edge entering RESP.
        if (state_d == S_RESP && state_q != S_RESP) begin
            req_ack_d  = NUM_REQ'(1) << cur_id_q;
            resp_vld_d = 1'b1;
            resp_id_d  = cur_id_q;
            if (resp_code_d == RESP_DUP && dup_cnt_q != '1) begin
                dup_cnt_d = dup_cnt_q + DUP_CNT_WIDTH'(1);
            end
        end else begin
            resp_code_d = RESP_PUSHED;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            rr_ptr_q       <= '0;
            cur_id_q       <= '0;
            cur_dat_q      <= '0;
            tmo_q          <= '0;
            dup_cnt_q      <= '0;
            served_q       <= 1'b0;
            req_ack_q      <= '0;
            resp_vld_q     <= 1'b0;
            resp_code_q    <= RESP_PUSHED;
            resp_id_q      <= '0;
            busy_q         <= 1'b0;
            ff_wren_q      <= 1'b0;
            ff_wdat_q      <= '0;
            ff_check_req_q <= 1'b0;
            ff_check_dat_q <= '0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            cur_id_q       <= cur_id_d;
            cur_dat_q      <= cur_dat_d;
            tmo_q          <= tmo_d;
            dup_cnt_q      <= dup_cnt_d;
            served_q       <= (state_q == S_RESP);
            req_ack_q      <= req_ack_d;
            resp_vld_q     <= resp_vld_d;
            resp_code_q    <= resp_code_d;
            resp_id_q      <= resp_id_d;
            busy_q         <= busy_d;
            ff_wren_q      <= ff_wren_d;
            ff_wdat_q      <= ff_wdat_d;
            ff_check_req_q <= ff_check_req_d;
            ff_check_dat_q <= ff_check_dat_d;
        end
    end

    assign bus.req_ack      = req_ack_q;
    assign bus.resp_vld     = resp_vld_q;
    assign bus.resp_code    = resp_code_q;
    assign bus.resp_id      = resp_id_q;
    assign bus.busy         = busy_q;
    assign bus.dup_cnt      = dup_cnt_q;
    assign bus.ff_wren      = ff_wren_q;
    assign bus.ff_wdat      = ff_wdat_q;
    assign bus.ff_check_req = ff_check_req_q;
    assign bus.ff_check_dat = ff_check_dat_q;

endmodule

// File: tb/tb_fifo_uniq_push_arb.sv
// Directed bench for fifo_uniq_push_arb: one task per scenario with a cycle-stepping
// FIFO-check responder; latencies are counted from the grant (IDLE) cycle.
module tb_fifo_uniq_push_arb;

    localparam int CHK_T = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    fifo_uniq_push_arb_if #(.NUM_REQ(4), .ID_WIDTH(2), .DATA_WIDTH(32)) bus ();

    fifo_uniq_push_arb #(
        .NUM_REQ     (4),
        .ID_WIDTH    (2),
        .DATA_WIDTH  (32),
        .CHK_TIMEOUT (CHK_T)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst              = 1'b1;
        bus.req_vld      = '0;
        bus.ff_check_vld = 1'b0;
        bus.ff_check_res = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Steps from the grant cycle until an ack, acting as the FIFO check responder.
    // chk_delay < 0 means ff_check_vld is never returned.
    task automatic run_txn(input int max_cyc, input int chk_delay, input logic chk_res,
                           input logic full_on_vld, input logic drop_on_ack,
                           output int lat, output logic [3:0] ack, output logic [1:0] code,
                           output logic [1:0] id, output logic rv, output int n_wren,
                           output logic [31:0] wdat, output int n_chk, output int chk_bad);
        int          chk_at;
        int          wait_end;
        logic [31:0] chk_val;
        logic        done;
        lat = 0; ack = '0; code = '0; id = '0; rv = 1'b0; n_wren = 0; wdat = '0;
        n_chk = 0; chk_bad = 0; chk_at = -1; wait_end = -1; chk_val = '0; done = 1'b0;
        while (!done && lat < max_cyc) begin
            tick();
            lat++;
            bus.ff_check_vld = 1'b0;
            bus.ff_check_res = 1'b0;
            if (bus.ff_wren) begin
                n_wren++;
                wdat = bus.ff_wdat;
            end
            if (bus.ff_check_req) begin
                n_chk++;
                chk_at   = lat;
                chk_val  = bus.ff_check_dat;
                wait_end = (chk_delay < 0) ? chk_at + CHK_T : chk_at + 1 + chk_delay;
            end else if (chk_at >= 0 && lat <= wait_end && bus.ff_check_dat !== chk_val) begin
                chk_bad++;
            end
            if (chk_at >= 0 && chk_delay >= 0 && lat == chk_at + 1 + chk_delay) begin
                bus.ff_check_vld = 1'b1;
                bus.ff_check_res = chk_res;
                if (full_on_vld) bus.ff_full = 1'b1;
            end
            if (bus.req_ack != '0) begin
                done = 1'b1;
                ack  = bus.req_ack;
                code = bus.resp_code;
                id   = bus.resp_id;
                rv   = bus.resp_vld;
            end
        end
        if (done) begin
            if (drop_on_ack) bus.req_vld = bus.req_vld & ~ack;
            tick();
        end
    endtask

    int          lat, n_wren, n_chk, chk_bad;
    logic [3:0]  ack;
    logic [1:0]  code, id;
    logic        rv;
    logic [31:0] wdat;

    task automatic test_reset();
        bus.ff_full  = 1'b0;
        bus.ff_empty = 1'b1;
        bus.req_dat  = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'hC0DE_0000};
        bus.req_vld  = 4'b1111;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if ({bus.req_ack, bus.resp_vld, bus.resp_code, bus.resp_id, bus.busy, bus.dup_cnt,
                 bus.ff_wren, bus.ff_wdat, bus.ff_check_req, bus.ff_check_dat} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs cycle %0d: got ack=%b busy=%b wren=%b want all 0",
                         i, bus.req_ack, bus.busy, bus.ff_wren);
            end
        end
        rst = 1'b0;
        run_txn(20, -1, 1'b0, 1'b0, 1'b0, lat, ack, code, id, rv, n_wren, wdat, n_chk, chk_bad);
        bus.req_vld = '0;
        n_tests++;
        if (ack !== 4'b0001 || id !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_first_grant: got ack=%b id=%0d want ack=0001 id=0", ack, id);
        end
        n_tests++;
        if (lat !== 3 || wdat !== 32'hC0DE_0000) begin
            n_fail++;
            $display("FAIL reset_first_push: got lat=%0d wdat=%h want lat=3 wdat=c0de0000",
                     lat, wdat);
        end
        tick();
    endtask

    task automatic test_empty_push();
        do_reset();
        bus.ff_full  = 1'b0;
        bus.ff_empty = 1'b1;
        bus.req_dat  = {32'h0BAD_0003, 32'hDEAD_BEEF, 32'h0BAD_0001, 32'h0BAD_0000};
        bus.req_vld  = 4'b0100;
        run_txn(20, -1, 1'b0, 1'b0, 1'b1, lat, ack, code, id, rv, n_wren, wdat, n_chk, chk_bad);
        n_tests++;
        if (lat !== 3) begin
            n_fail++;
            $display("FAIL empty_latency: got %0d want 3", lat);
        end
        n_tests++;
        if (ack !== 4'b0100 || id !== 2'd2 || code !== 2'd0 || rv !== 1'b1) begin
            n_fail++;
            $display("FAIL empty_resp: got ack=%b id=%0d code=%0d vld=%b want 0100 2 0 1",
                     ack, id, code, rv);
        end
        n_tests++;
        if (n_chk !== 0 || n_wren !== 1 || wdat !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL empty_write: got chk=%0d wren=%0d wdat=%h want 0 1 deadbeef",
                     n_chk, n_wren, wdat);
        end
    endtask

    task automatic test_dup();
        do_reset();
        bus.ff_full  = 1'b0;
        bus.ff_empty = 1'b0;
        bus.req_dat  = {32'hA5A5_0003, 32'h0, 32'h1234_5678, 32'h0};
        n_tests++;
        if (bus.dup_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL dup_cnt_init: got %0d want 0", bus.dup_cnt);
        end
        bus.req_vld = 4'b0010;
        run_txn(40, 5, 1'b1, 1'b0, 1'b1, lat, ack, code, id, rv, n_wren, wdat, n_chk, chk_bad);
        n_tests++;
        if (lat !== 9 || code !== 2'd1 || id !== 2'd1) begin
            n_fail++;
            $display("FAIL dup_resp: got lat=%0d code=%0d id=%0d want 9 1 1", lat, code, id);
        end
        n_tests++;
        if (n_wren !== 0 || n_chk !== 1 || chk_bad !== 0) begin
            n_fail++;
            $display("FAIL dup_check: got wren=%0d chk=%0d unstable=%0d want 0 1 0",
                     n_wren, n_chk, chk_bad);
        end
        n_tests++;
        if (bus.dup_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL dup_cnt_inc: got %0d want 1", bus.dup_cnt);
        end
        bus.req_vld = 4'b1000;
        run_txn(40, 2, 1'b0, 1'b0, 1'b1, lat, ack, code, id, rv, n_wren, wdat, n_chk, chk_bad);
        n_tests++;
        if (lat !== 7 || code !== 2'd0 || n_wren !== 1 || wdat !== 32'hA5A5_0003) begin
            n_fail++;
            $display("FAIL checked_push: got lat=%0d code=%0d wren=%0d wdat=%h want 7 0 1 a5a50003",
                     lat, code, n_wren, wdat);
        end
        n_tests++;
        if (bus.dup_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL dup_cnt_hold: got %0d want 1", bus.dup_cnt);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] prev;
        do_reset();
        bus.ff_full  = 1'b0;
        bus.ff_empty = 1'b1;
        bus.req_dat  = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
        bus.req_vld  = 4'b1111;
        prev = 2'd3;
        for (int i = 0; i < 5; i++) begin
            run_txn(20, -1, 1'b0, 1'b0, 1'b0, lat, ack, code, id, rv, n_wren, wdat, n_chk,
                    chk_bad);
            n_tests++;
            if (id !== 2'(i % 4) || lat !== 3 || (i > 0 && id === prev)) begin
                n_fail++;
                $display("FAIL rr_order grant %0d: got id=%0d lat=%0d want id=%0d lat=3",
                         i, id, lat, i % 4);
            end
            prev = id;
        end
        bus.req_vld = '0;
        tick();
    endtask

    task automatic test_full();
        do_reset();
        bus.ff_full  = 1'b1;
        bus.ff_empty = 1'b0;
        bus.req_dat  = {32'h0, 32'h7777_0002, 32'h0, 32'h7777_0000};
        bus.req_vld  = 4'b0001;
        run_txn(20, -1, 1'b0, 1'b0, 1'b1, lat, ack, code, id, rv, n_wren, wdat, n_chk, chk_bad);
        n_tests++;
        if (lat !== 2 || code !== 2'd2 || n_chk !== 0 || n_wren !== 0) begin
            n_fail++;
            $display("FAIL full_eval: got lat=%0d code=%0d chk=%0d wren=%0d want 2 2 0 0",
                     lat, code, n_chk, n_wren);
        end
        bus.ff_full = 1'b0;
        bus.req_vld = 4'b0100;
        run_txn(40, 3, 1'b0, 1'b1, 1'b1, lat, ack, code, id, rv, n_wren, wdat, n_chk, chk_bad);
        n_tests++;
        if (lat !== 8 || code !== 2'd2 || n_chk !== 1 || n_wren !== 0 || id !== 2'd2) begin
            n_fail++;
            $display("FAIL full_write: got lat=%0d code=%0d chk=%0d wren=%0d id=%0d want 8 2 1 0 2",
                     lat, code, n_chk, n_wren, id);
        end
        bus.ff_full = 1'b0;
    endtask

    task automatic test_timeout_and_abort();
        int bad;
        do_reset();
        bus.ff_full  = 1'b0;
        bus.ff_empty = 1'b0;
        bus.req_dat  = {32'h5EED_0003, 32'h0, 32'h5EED_0001, 32'h0};
        bus.req_vld  = 4'b1000;
        run_txn(100, -1, 1'b0, 1'b0, 1'b1, lat, ack, code, id, rv, n_wren, wdat, n_chk, chk_bad);
        n_tests++;
        if (lat !== 3 + CHK_T || code !== 2'd3 || id !== 2'd3) begin
            n_fail++;
            $display("FAIL timeout_resp: got lat=%0d code=%0d id=%0d want %0d 3 3",
                     lat, code, id, 3 + CHK_T);
        end
        n_tests++;
        if (n_wren !== 0 || n_chk !== 1 || chk_bad !== 0) begin
            n_fail++;
            $display("FAIL timeout_check: got wren=%0d chk=%0d unstable=%0d want 0 1 0",
                     n_wren, n_chk, chk_bad);
        end
        bus.req_vld = 4'b0010;
        for (int i = 0; i < 4; i++) tick();
        n_tests++;
        if (bus.busy !== 1'b1 || bus.ff_check_dat !== 32'h5EED_0001) begin
            n_fail++;
            $display("FAIL abort_in_wait: got busy=%b chk_dat=%h want 1 5eed0001",
                     bus.busy, bus.ff_check_dat);
        end
        rst         = 1'b1;
        bus.req_vld = '0;
        tick();
        rst = 1'b0;
        n_tests++;
        if (bus.busy !== 1'b0 || bus.req_ack !== 4'b0 || bus.ff_check_dat !== 32'h0) begin
            n_fail++;
            $display("FAIL abort_reset: got busy=%b ack=%b chk_dat=%h want 0 0000 0",
                     bus.busy, bus.req_ack, bus.ff_check_dat);
        end
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.req_ack !== 4'b0 || bus.ff_wren !== 1'b0 || bus.busy !== 1'b0) bad++;
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL abort_quiet: got %0d active cycles want 0", bad);
        end
    endtask

    initial begin
        bus.req_vld      = '0;
        bus.req_dat      = '0;
        bus.ff_full      = 1'b0;
        bus.ff_empty     = 1'b1;
        bus.ff_check_res = 1'b0;
        bus.ff_check_vld = 1'b0;
        test_reset();
        test_empty_push();
        test_dup();
        test_round_robin();
        test_full();
        test_timeout_and_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
